// File: rtl/uart_rx_ip_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register offsets,
// STATUS bit positions, receive FSM encodings and the reset divisor helper.
package uart_rx_ip_pkg;

  localparam logic [3:0] UART_RX_DATA   = 4'h0;
  localparam logic [3:0] UART_RX_STATUS = 4'h4;
  localparam logic [3:0] UART_RX_CTRL   = 4'h8;
  localparam logic [3:0] UART_RX_DIV    = 4'hC;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_COUNT_LSB = 4;

  localparam int CTRL_EN = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;

  // Tick divisor that yields 'os' ticks per bit at 'baud' from 'clk_hz'.
  function automatic logic [15:0] reset_div(input int clk_hz, input int baud, input int os);
    return 16'(clk_hz / (baud * os) - 1);
  endfunction

endpackage

// File: rtl/uart_rx_ip_fifo.sv
// Byte FIFO for received characters. Push while full is refused unless a pop
// happens in the same cycle, in which case both take effect.
module uart_rx_ip_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  output logic [7:0]               dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ip.sv
// Memory-mapped 8N1 UART receiver: rxd synchronizer, oversampling tick
// generator, receive FSM, register file and RX FIFO.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | line idle, waiting for a low level on a tick
// S_START | confirming the start bit at its centre (glitch filter)
// S_DATA  | sampling 8 data bits LSB first, one every 16 ticks
// S_STOP  | sampling the stop bit; on a low stop, wait for line high
module uart_rx_ip
  import uart_rx_ip_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 8,
  parameter int OVERSAMPLE  = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic        i_re,
  input  logic [3:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  input  logic        rxd,
  output logic        o_irq
);

  localparam logic [15:0] DIV_RST = reset_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int          OSW     = $clog2(OVERSAMPLE);
  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  // Down-counter reloads: N-1 expires N ticks later.
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 2);

  logic            rxd_meta_q, rxd_sync_q;
  logic [15:0]     tick_cnt_q, div_q;
  logic            tick;
  rx_state_e       state_q;
  logic [OSW-1:0]  os_cnt_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            push_q, frame_evt_q, brk_q;
  logic            en_q, overrun_q, frame_err_q;
  logic [31:0]     rdata_q, rd_mux;
  logic            bus_rd, bus_wr, ctrl_wr, div_wr;
  logic            fifo_pop, fifo_full, fifo_empty, overrun_evt;
  logic [7:0]      fifo_dout;
  logic [CW-1:0]   fifo_count;
  logic            unused_wdata;

  assign bus_rd   = i_sel && i_re;
  assign bus_wr   = i_sel && i_we;
  assign ctrl_wr  = bus_wr && (i_addr == UART_RX_CTRL);
  assign div_wr   = bus_wr && (i_addr == UART_RX_DIV);
  assign fifo_pop = bus_rd && (i_addr == UART_RX_DATA) && !fifo_empty;
  // A pop in the same cycle frees the slot, so that push is not an overrun.
  assign overrun_evt = push_q && fifo_full && !fifo_pop;
  assign tick        = (tick_cnt_q == 16'd0);
  assign unused_wdata = ^i_wdata[31:16];

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  // Tick down-counter: one tick every DIV+1 clocks, restarted on a DIV write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   tick_cnt_q <= DIV_RST;
    else if (div_wr) tick_cnt_q <= i_wdata[15:0];
    else if (tick) tick_cnt_q <= div_q;
    else           tick_cnt_q <= tick_cnt_q - 16'd1;
  end

  // Receive FSM with registered push and frame-error pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_evt_q <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_evt_q <= 1'b0;
      if (!en_q) begin
        state_q <= S_IDLE;
        brk_q   <= 1'b0;
      end else if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (!rxd_sync_q) begin
              state_q  <= S_START;
              os_cnt_q <= OS_MID;
            end
          end
          S_START: begin
            if (os_cnt_q == '0) begin
              if (rxd_sync_q) begin
                state_q <= S_IDLE;
              end else begin
                state_q   <= S_DATA;
                os_cnt_q  <= OS_LAST;
                bit_cnt_q <= 3'd0;
              end
            end else begin
              os_cnt_q <= os_cnt_q - OSW'(1);
            end
          end
          S_DATA: begin
            if (os_cnt_q == '0) begin
              shift_q  <= {rxd_sync_q, shift_q[7:1]};
              os_cnt_q <= OS_LAST;
              if (bit_cnt_q == 3'd7) state_q <= S_STOP;
              else                   bit_cnt_q <= bit_cnt_q + 3'd1;
            end else begin
              os_cnt_q <= os_cnt_q - OSW'(1);
            end
          end
          S_STOP: begin
            // After a bad stop bit, hold here until the line goes high so a
            // break is not re-read as a stream of zero bytes.
            if (brk_q) begin
              if (rxd_sync_q) begin
                brk_q   <= 1'b0;
                state_q <= S_IDLE;
              end
            end else if (os_cnt_q == '0) begin
              if (rxd_sync_q) begin
                push_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                frame_evt_q <= 1'b1;
                brk_q       <= 1'b1;
              end
            end else begin
              os_cnt_q <= os_cnt_q - OSW'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Control, divisor and sticky error flags; a new event wins over W1C.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en_q        <= 1'b1;
      div_q       <= DIV_RST;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (ctrl_wr) en_q  <= i_wdata[CTRL_EN];
      if (div_wr)  div_q <= i_wdata[15:0];
      overrun_q   <= overrun_evt |
                     (overrun_q & ~(ctrl_wr & i_wdata[ST_OVERRUN]));
      frame_err_q <= frame_evt_q |
                     (frame_err_q & ~(ctrl_wr & i_wdata[ST_FRAME_ERR]));
    end
  end

  // Read mux; DATA shows the pre-pop head, or 0 when empty.
  always_comb begin
    rd_mux = 32'd0;
    case (i_addr)
      UART_RX_DATA: begin
        if (!fifo_empty) rd_mux = {23'd0, 1'b1, fifo_dout};
      end
      UART_RX_STATUS: begin
        rd_mux[ST_NOT_EMPTY]               = !fifo_empty;
        rd_mux[ST_FULL]                    = fifo_full;
        rd_mux[ST_OVERRUN]                 = overrun_q;
        rd_mux[ST_FRAME_ERR]               = frame_err_q;
        rd_mux[ST_COUNT_LSB +: 8]          = 8'(fifo_count);
      end
      UART_RX_CTRL: rd_mux[CTRL_EN] = en_q;
      UART_RX_DIV:  rd_mux[15:0]    = div_q;
      default:      rd_mux = 32'd0;
    endcase
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     rdata_q <= 32'd0;
    else if (bus_rd) rdata_q <= rd_mux;
  end

  assign o_rdata = rdata_q;
  assign o_irq   = !fifo_empty || overrun_q || frame_err_q;

  uart_rx_ip_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push_q),
    .din_i   (shift_q),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_ip.sv
// Scoreboard bench for uart_rx_ip: reads queue their expected value, and a
// monitor compares o_rdata one cycle after each read strobe.
module tb_uart_rx_ip;

  localparam int BIT_SLOW = 1248;
  localparam int BIT_FAST = 64;
  localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_CTRL = 4'h8, A_DIV = 4'hC;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_sel = 1'b0, i_we = 1'b0, i_re = 1'b0;
  logic [3:0]  i_addr = 4'h0;
  logic [31:0] i_wdata = 32'd0;
  logic        rxd = 1'b1;
  logic [31:0] o_rdata;
  logic        o_irq;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  uart_rx_ip dut (
    .clk     (clk),
    .resetn  (resetn),
    .i_sel   (i_sel),
    .i_we    (i_we),
    .i_re    (i_re),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .o_rdata (o_rdata),
    .rxd     (rxd),
    .o_irq   (o_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Monitor: o_rdata is valid one cycle after a sampled read strobe.
  always @(posedge clk) begin
    if (i_sel && i_re) begin
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_underflow: read with no expected value, got 0x%0h", o_rdata);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string       n = name_q.pop_front();
        check(n, o_rdata, e);
      end
    end
  end

  // All bus tasks start and end on a falling edge.
  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    i_sel = 1'b1; i_re = 1'b1; i_addr = a;
    @(negedge clk);
    i_sel = 1'b0; i_re = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    i_sel = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
    @(negedge clk);
    i_sel = 1'b0; i_we = 1'b0; i_wdata = 32'd0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input int bclk, input int stop_clks, input logic stop_val);
    rxd = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (bclk) @(negedge clk);
    end
    rxd = stop_val;
    repeat (stop_clks) @(negedge clk);
    rxd = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;

    // Reset, then a frame cut short by a second reset.
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    rxd = 1'b0;
    repeat (BIT_SLOW) @(negedge clk);
    rxd = 1'b1;
    repeat (BIT_SLOW) @(negedge clk);
    rxd = 1'b0;
    repeat (2 * BIT_SLOW) @(negedge clk);
    resetn = 1'b0;
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    check("rdata_after_reset", o_rdata, 32'd0);
    check("irq_after_reset", {31'd0, o_irq}, 32'd0);
    repeat (2 * BIT_SLOW) @(negedge clk);
    rd(A_DATA, 32'd0,  "data_reset");
    rd(A_STAT, 32'd0,  "status_reset");
    rd(A_DIV,  32'd77, "div_reset");
    rd(A_CTRL, 32'd1,  "ctrl_reset");

    // Single byte 0xA5 at the reset baud rate.
    fork
      send_byte(8'hA5, BIT_SLOW, BIT_SLOW, 1'b1);
      begin
        repeat (5 * BIT_SLOW) @(negedge clk);
        rd(A_STAT, 32'd0, "status_before_push");
      end
    join
    rd(A_STAT, 32'h11, "status_one_byte");
    check("irq_one_byte", {31'd0, o_irq}, 32'd1);
    rd(A_DATA, 32'h1A5, "data_a5");
    rd(A_STAT, 32'd0, "status_after_pop");
    check("irq_after_pop", {31'd0, o_irq}, 32'd0);

    // Framing error: stop bit held low for two bit times.
    send_byte(8'h3C, BIT_SLOW, 2 * BIT_SLOW, 1'b0);
    repeat (BIT_SLOW) @(negedge clk);
    rd(A_STAT, 32'h8, "status_frame_err");
    check("irq_frame_err", {31'd0, o_irq}, 32'd1);
    wr(A_CTRL, 32'h9);
    rd(A_STAT, 32'd0, "status_frame_cleared");
    check("irq_frame_cleared", {31'd0, o_irq}, 32'd0);

    // Short low glitch is rejected by the start-bit check.
    rxd = 1'b0;
    repeat (300) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * BIT_SLOW) @(negedge clk);
    rd(A_STAT, 32'd0, "status_glitch");

    // Faster divisor.
    wr(A_DIV, 32'd3);
    rd(A_DIV, 32'd3, "div_written");
    send_byte(8'h5A, BIT_FAST, BIT_FAST, 1'b1);
    repeat (BIT_FAST) @(negedge clk);
    rd(A_DATA, 32'h15A, "data_5a_fast");

    // Receiver disabled: frame ignored.
    wr(A_CTRL, 32'h0);
    rd(A_CTRL, 32'h0, "ctrl_disabled");
    send_byte(8'h77, BIT_FAST, BIT_FAST, 1'b1);
    repeat (BIT_FAST) @(negedge clk);
    rd(A_STAT, 32'd0, "status_disabled");
    wr(A_CTRL, 32'h1);

    // Fill and overrun: nine bytes into eight entries.
    for (int k = 1; k <= 9; k++) send_byte(8'(k), BIT_FAST, BIT_FAST, 1'b1);
    repeat (BIT_FAST) @(negedge clk);
    rd(A_STAT, 32'h87, "status_full_overrun");
    for (int k = 1; k <= 8; k++) rd(A_DATA, 32'h100 | k, $sformatf("data_fill_%0d", k));
    rd(A_DATA, 32'd0, "data_empty");
    rd(A_STAT, 32'h4, "status_overrun_only");
    check("irq_overrun", {31'd0, o_irq}, 32'd1);
    wr(A_CTRL, 32'h5);
    rd(A_STAT, 32'd0, "status_overrun_cleared");
    check("irq_overrun_cleared", {31'd0, o_irq}, 32'd0);

    // Push and pop in the same cycle while full.
    for (int k = 8'h11; k <= 8'h18; k++) send_byte(8'(k), BIT_FAST, BIT_FAST, 1'b1);
    repeat (BIT_FAST) @(negedge clk);
    rd(A_STAT, 32'h83, "status_full8");
    found = 1'b0;
    fork
      send_byte(8'h19, BIT_FAST, BIT_FAST, 1'b1);
      begin
        for (int c = 0; c < 15 * BIT_FAST && !found; c++) begin
          @(negedge clk);
          if (dut.push_q) found = 1'b1;
        end
        if (found) rd(A_DATA, 32'h111, "data_pop_at_push");
        else begin
          n_checks++;
          $display("FAIL push_wait: no push seen within %0d cycles, required 1 push", 15 * BIT_FAST);
        end
      end
    join
    repeat (BIT_FAST) @(negedge clk);
    rd(A_STAT, 32'h83, "status_full_no_overrun");
    for (int k = 8'h12; k <= 8'h19; k++) rd(A_DATA, 32'h100 | k, $sformatf("data_order_%0h", k));
    rd(A_STAT, 32'd0, "status_drained");

    repeat (4) @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL sb_leftover: %0d pending, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
